// File: rtl/tc_uart_pkg.sv
// Shared constants for the tc_uart host: command opcodes, response headers,
// TX/RX FSM state encodings and the per-opcode argument-length lookup.
// No logic; imported by tc_uart_host and tc_resp_decoder.
package tc_uart_pkg;

  // Host -> core command opcodes
  localparam logic [7:0] OP_GET_ID   = 8'h01;
  localparam logic [7:0] OP_GET_CFG  = 8'h02;
  localparam logic [7:0] OP_WORD     = 8'h03;
  localparam logic [7:0] OP_XY       = 8'h04;
  localparam logic [7:0] OP_STR      = 8'h05;
  localparam logic [7:0] OP_BYTE_A   = 8'h06;
  localparam logic [7:0] OP_BLOCK    = 8'h07;
  localparam logic [7:0] OP_BYTE_B   = 8'h08;

  // Core -> host response headers
  localparam logic [7:0] RSP_JOY = 8'h01;
  localparam logic [7:0] RSP_CID = 8'h11;
  localparam logic [7:0] RSP_CFG = 8'h22;

  typedef enum logic [2:0] {
    TX_IDLE, TX_OPCODE, TX_ARGS, TX_PAYLOAD, TX_WAITRESP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_HDR, RX_JOY, RX_CID, RX_CFG
  } rx_state_t;

  // Number of cmd_arg bytes that follow the opcode on the wire.
  function automatic logic [2:0] arg_len(input logic [7:0] op);
    case (op)
      OP_WORD:             arg_len = 3'd4;
      OP_XY:               arg_len = 3'd2;
      OP_BYTE_A, OP_BYTE_B: arg_len = 3'd1;
      OP_BLOCK:            arg_len = 3'd3;
      default:             arg_len = 3'd0;
    endcase
  endfunction

  function automatic logic op_legal(input logic [7:0] op);
    op_legal = (op >= OP_GET_ID) && (op <= OP_BYTE_B);
  endfunction

endpackage

// File: rtl/tc_resp_decoder.sv
// Decodes core->host response frames (joypad, core ID, config string) from the RX byte stream.
// Latency: outputs/strobes registered one cycle after the completing byte.
// Backpressure: none; consumes one byte per rx_vld.
module tc_resp_decoder
  import tc_uart_pkg::*;
#(
  parameter int unsigned STR_MAX = 128
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_dat,
  input  logic        rx_vld,
  output logic [7:0]  core_id,
  output logic        core_id_valid,
  output logic [7:0]  cfg_byte,
  output logic        cfg_valid,
  output logic        cfg_done,
  output logic [15:0] joy1,
  output logic [15:0] joy2,
  output logic        joy_update,
  output logic        err
);

  localparam int CW = $clog2(STR_MAX + 1);

  rx_state_t   state;
  logic [1:0]  jcnt;
  logic [7:0]  j0, j1, j2;
  logic [CW-1:0] scnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RX_HDR;
      jcnt <= '0; j0 <= '0; j1 <= '0; j2 <= '0; scnt <= '0;
      core_id <= '0; core_id_valid <= 1'b0;
      cfg_byte <= '0; cfg_valid <= 1'b0; cfg_done <= 1'b0;
      joy1 <= '0; joy2 <= '0; joy_update <= 1'b0;
      err <= 1'b0;
    end else begin
      core_id_valid <= 1'b0;
      cfg_valid     <= 1'b0;
      cfg_done      <= 1'b0;
      joy_update    <= 1'b0;
      err           <= 1'b0;
      if (rx_vld) begin
        case (state)
          RX_HDR: begin
            case (rx_dat)
              RSP_JOY: begin state <= RX_JOY; jcnt <= '0; end
              RSP_CID: state <= RX_CID;
              RSP_CFG: begin state <= RX_CFG; scnt <= '0; end
              default: err <= 1'b1;
            endcase
          end
          RX_JOY: begin
            jcnt <= jcnt + 2'd1;
            if (jcnt == 2'd0)      j0 <= rx_dat;
            else if (jcnt == 2'd1) j1 <= rx_dat;
            else if (jcnt == 2'd2) j2 <= rx_dat;
            else begin
              // Both pads commit together so consumers never see a torn update.
              joy1       <= {j1, j0};
              joy2       <= {rx_dat, j2};
              joy_update <= 1'b1;
              state      <= RX_HDR;
            end
          end
          RX_CID: begin
            core_id       <= rx_dat;
            core_id_valid <= 1'b1;
            state         <= RX_HDR;
          end
          RX_CFG: begin
            if (rx_dat == 8'h00) begin
              cfg_done <= 1'b1;
              state    <= RX_HDR;
            end else begin
              cfg_byte  <= rx_dat;
              cfg_valid <= 1'b1;
              scnt      <= scnt + CW'(1);
              // A runaway string is cut off after STR_MAX bytes.
              if (scnt == CW'(STR_MAX - 1)) begin
                cfg_done <= 1'b1;
                state    <= RX_HDR;
              end
            end
          end
          default: state <= RX_HDR;
        endcase
      end
    end
  end

endmodule

// File: rtl/tc_uart_rx.sv
// 8N1 UART receiver with fractional baud divider, sampling mid-bit.
// Latency: rx_vld pulses at the middle of the stop bit (plus 2-flop sync).
// Backpressure: none; rx_vld is a one-cycle strobe that must be consumed.
module tc_uart_rx #(
  parameter int unsigned DIV_NUM = 21477,
  parameter int unsigned DIV_DEN = 1000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rx,
  output logic [7:0] rx_dat,
  output logic       rx_vld
);

  logic [1:0]  sync;
  logic        rx_s;
  logic        active;
  logic [3:0]  cnt;
  logic [7:0]  sh;
  logic [31:0] acc;
  logic [31:0] acc_nxt;
  logic        tick;

  assign rx_s    = sync[1];
  assign acc_nxt = acc + DIV_DEN;
  assign tick    = acc_nxt >= DIV_NUM;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync   <= 2'b11;
      active <= 1'b0;
      cnt    <= '0;
      sh     <= '0;
      acc    <= '0;
      rx_dat <= '0;
      rx_vld <= 1'b0;
    end else begin
      sync   <= {sync[0], uart_rx};
      rx_vld <= 1'b0;
      if (!active) begin
        if (!rx_s) begin
          // Preload half a divider period so ticks land mid-bit.
          active <= 1'b1;
          acc    <= DIV_NUM / 2;
          cnt    <= '0;
        end
      end else begin
        acc <= tick ? acc_nxt - DIV_NUM : acc_nxt;
        if (tick) begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd0) begin
            if (rx_s) active <= 1'b0;  // start-bit glitch
          end else if (cnt == 4'd9) begin
            active <= 1'b0;
            rx_vld <= rx_s;            // drop frames with a bad stop bit
            rx_dat <= sh;
          end else begin
            sh <= {rx_s, sh[7:1]};
          end
        end
      end
    end
  end

endmodule

// File: rtl/tc_uart_tx.sv
// 8N1 UART transmitter with fractional baud divider (DIV_DEN/DIV_NUM ticks per clk).
// Latency: start bit driven the cycle after tx_vld&&tx_rdy; 10 bit times per byte.
// Backpressure: tx_rdy low for the whole frame including the stop bit.
module tc_uart_tx #(
  parameter int unsigned DIV_NUM = 21477,
  parameter int unsigned DIV_DEN = 1000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_dat,
  input  logic       tx_vld,
  output logic       tx_rdy,
  output logic       uart_tx
);

  logic        active;
  logic [9:0]  sh;
  logic [3:0]  cnt;
  logic [31:0] acc;
  logic [31:0] acc_nxt;
  logic        tick;

  assign acc_nxt = acc + DIV_DEN;
  assign tick    = acc_nxt >= DIV_NUM;
  assign tx_rdy  = !active;
  assign uart_tx = active ? sh[0] : 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active <= 1'b0;
      sh     <= '1;
      cnt    <= '0;
      acc    <= '0;
    end else if (!active) begin
      if (tx_vld) begin
        active <= 1'b1;
        sh     <= {1'b1, tx_dat, 1'b0};
        cnt    <= 4'd10;
        acc    <= '0;
      end
    end else begin
      acc <= tick ? acc_nxt - DIV_NUM : acc_nxt;
      if (tick) begin
        sh  <= {1'b1, sh[9:1]};
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tc_uart_host.sv
// Host-side command/response bridge to a core over an 8N1 UART; optional response timeout via TC_UART_HOST_TIMEOUT_EN.
// Latency: opcode starts serialising the cycle after cmd transfer; responses decoded independently of the TX FSM.
// Backpressure: cmd_ready only in IDLE with the transmitter free; pl_ready only in PAYLOAD while the transmitter is free.
// Ports: cmd_op/cmd_arg/cmd_valid/cmd_ready command in; pl_data/pl_valid/pl_ready payload in;
//        core_id*, cfg_*, joy* decoded responses; busy, err status; uart_tx/uart_rx serial pins.
module tc_uart_host
  import tc_uart_pkg::*;
#(
  parameter int unsigned FREQ      = 21_477_000,
  parameter int unsigned BAUD_RATE = 1_000_000,
  parameter int unsigned STR_MAX   = 128
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  core_id,
  output logic        core_id_valid,
  output logic [7:0]  cfg_byte,
  output logic        cfg_valid,
  output logic        cfg_done,
  output logic [15:0] joy1,
  output logic [15:0] joy2,
  output logic        joy_update,
  output logic        busy,
  output logic        err,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int unsigned DIV_NUM = FREQ / 1000;
  localparam int unsigned DIV_DEN = BAUD_RATE / 1000;

  tx_state_t   state;
  logic [7:0]  op;
  logic [31:0] arg;
  logic [1:0]  idx;
  logic [23:0] remain;
  logic        armed;
  logic        tx_err;
  logic [2:0]  nargs;
  logic [1:0]  byte_sel;
  logic [7:0]  tx_dat;
  logic        tx_vld, tx_rdy, tx_fire;
  logic [7:0]  rx_dat;
  logic        rx_vld, rx_err;
`ifdef TC_UART_HOST_TIMEOUT_EN
  localparam int unsigned TIMEOUT = FREQ / 10;
  logic [31:0] wait_cnt;
`endif

  assign nargs    = arg_len(op);
  // Arguments go out most-significant byte first.
  assign byte_sel = 2'(nargs - 3'd1 - {1'b0, idx});

  always_comb begin
    tx_vld = 1'b0;
    tx_dat = op;
    case (state)
      TX_OPCODE:  tx_vld = 1'b1;
      TX_ARGS:    begin tx_vld = 1'b1; tx_dat = arg[{byte_sel, 3'b000} +: 8]; end
      TX_PAYLOAD: begin tx_vld = pl_valid; tx_dat = pl_data; end
      default:    tx_vld = 1'b0;
    endcase
  end

  assign tx_fire   = tx_vld && tx_rdy;
  // armed keeps cmd_ready low through reset and rises on the first edge after release.
  assign cmd_ready = armed && (state == TX_IDLE) && tx_rdy;
  assign pl_ready  = (state == TX_PAYLOAD) && tx_rdy;
  assign busy      = (state != TX_IDLE);
  assign err       = tx_err | rx_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= TX_IDLE;
      op     <= '0;
      arg    <= '0;
      idx    <= '0;
      remain <= '0;
      armed  <= 1'b0;
      tx_err <= 1'b0;
`ifdef TC_UART_HOST_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      armed  <= 1'b1;
      tx_err <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op  <= cmd_op;
            arg <= cmd_arg;
            idx <= '0;
            if (op_legal(cmd_op)) state <= TX_OPCODE;
            else tx_err <= 1'b1;
          end
        end
        TX_OPCODE: begin
          if (tx_fire) begin
            if (nargs != 3'd0) state <= TX_ARGS;
            else if (op == OP_STR) state <= TX_PAYLOAD;
            else begin
              state <= TX_WAITRESP;  // only GET_ID / GET_CFG remain
`ifdef TC_UART_HOST_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end
          end
        end
        TX_ARGS: begin
          if (tx_fire) begin
            if ({1'b0, idx} == nargs - 3'd1) begin
              if (op == OP_BLOCK && arg[23:0] != 24'd0) begin
                state  <= TX_PAYLOAD;
                remain <= arg[23:0];
              end else begin
                state <= TX_IDLE;
              end
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        TX_PAYLOAD: begin
          if (tx_fire) begin
            if (op == OP_STR) begin
              // The NUL terminator is itself sent before leaving.
              if (pl_data == 8'h00) state <= TX_IDLE;
            end else begin
              remain <= remain - 24'd1;
              if (remain == 24'd1) state <= TX_IDLE;
            end
          end
        end
        TX_WAITRESP: begin
          if ((op == OP_GET_ID && core_id_valid) || (op == OP_GET_CFG && cfg_done)) begin
            state <= TX_IDLE;
          end
`ifdef TC_UART_HOST_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT - 1) begin
            tx_err <= 1'b1;
            state  <= TX_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
`endif
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  tc_uart_tx #(.DIV_NUM(DIV_NUM), .DIV_DEN(DIV_DEN)) u_tx (
    .clk(clk), .resetn(resetn),
    .tx_dat(tx_dat), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .uart_tx(uart_tx)
  );

  tc_uart_rx #(.DIV_NUM(DIV_NUM), .DIV_DEN(DIV_DEN)) u_rx (
    .clk(clk), .resetn(resetn),
    .uart_rx(uart_rx), .rx_dat(rx_dat), .rx_vld(rx_vld)
  );

  tc_resp_decoder #(.STR_MAX(STR_MAX)) u_dec (
    .clk(clk), .resetn(resetn),
    .rx_dat(rx_dat), .rx_vld(rx_vld),
    .core_id(core_id), .core_id_valid(core_id_valid),
    .cfg_byte(cfg_byte), .cfg_valid(cfg_valid), .cfg_done(cfg_done),
    .joy1(joy1), .joy2(joy2), .joy_update(joy_update),
    .err(rx_err)
  );

endmodule

// File: tb/tb_tc_uart_host.sv
// Directed bench for tc_uart_host: serial TX capture, serial RX injection,
// strobe counters and hand-computed expected bytes/values.
module tb_tc_uart_host;

  localparam int unsigned FREQ = 8_000_000;
  localparam int unsigned BAUD = 1_000_000;
  localparam int unsigned SMAX = 4;
  localparam int BIT = 8;  // clocks per UART bit at FREQ/BAUD

  logic        clk, resetn;
  logic [7:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  pl_data;
  logic        pl_valid, pl_ready;
  logic [7:0]  core_id, cfg_byte;
  logic        core_id_valid, cfg_valid, cfg_done, joy_update, busy, err;
  logic [15:0] joy1, joy2;
  logic        uart_tx, uart_rx;

  int checks = 0, failures = 0;
  int n_cid = 0, n_cfgv = 0, n_cfgd = 0, n_joy = 0, n_err = 0, n_pl = 0;
  logic [7:0] tx_q[$];
  logic [7:0] cfg_q[$];

  tc_uart_host #(.FREQ(FREQ), .BAUD_RATE(BAUD), .STR_MAX(SMAX)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .core_id(core_id), .core_id_valid(core_id_valid),
    .cfg_byte(cfg_byte), .cfg_valid(cfg_valid), .cfg_done(cfg_done),
    .joy1(joy1), .joy2(joy2), .joy_update(joy_update),
    .busy(busy), .err(err), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial capture of uart_tx, sampled mid-bit on falling edges.
  always begin : tx_mon
    logic [7:0] b;
    b = 8'h00;
    @(negedge clk);
    if (resetn && uart_tx === 1'b0) begin
      repeat (BIT/2) @(negedge clk);
      if (uart_tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (BIT) @(negedge clk);
        if (uart_tx === 1'b1) tx_q.push_back(b);
      end
    end
  end

  always @(negedge clk) begin
    if (core_id_valid) n_cid <= n_cid + 1;
    if (cfg_valid) begin n_cfgv <= n_cfgv + 1; cfg_q.push_back(cfg_byte); end
    if (cfg_done) n_cfgd <= n_cfgd + 1;
    if (joy_update) n_joy <= n_joy + 1;
    if (err) n_err <= n_err + 1;
    if (pl_valid && pl_ready) n_pl <= n_pl + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] qcat();
    logic [63:0] r;
    r = '0;
    foreach (tx_q[i]) r = {r[55:0], tx_q[i]};
    return r;
  endfunction

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] a);
    @(posedge clk); #1;
    cmd_op = op; cmd_arg = a; cmd_valid = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 3000 && !cmd_ready; t++) @(negedge clk);
    chk("cmd_accept", {63'b0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_pl(input logic [7:0] d);
    @(posedge clk); #1;
    pl_data = d; pl_valid = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 3000 && !pl_ready; t++) @(negedge clk);
    chk("pl_accept", {63'b0, pl_ready}, 64'd1);
    @(posedge clk); #1;
    pl_valid = 1'b0;
  endtask

  task automatic wait_idle();
    @(negedge clk);
    for (int t = 0; t < 3000 && !cmd_ready; t++) @(negedge clk);
    chk("idle_wait", {63'b0, cmd_ready}, 64'd1);
  endtask

  task automatic wait_txn(input int n);
    @(negedge clk);
    for (int t = 0; t < 3000 && tx_q.size() < n; t++) @(negedge clk);
    chk("txq_wait", 64'(tx_q.size() >= n), 64'd1);
  endtask

  task automatic rx_byte(input logic [7:0] d);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; cmd_op = '0; cmd_arg = '0; cmd_valid = 1'b0;
    pl_data = '0; pl_valid = 1'b0; uart_rx = 1'b1;
    settle(3);
    chk("rst_uart_tx", {63'b0, uart_tx}, 64'd1);
    chk("rst_rdy_busy", {cmd_ready, pl_ready, busy, err}, 64'h0);
    chk("rst_strobes", {core_id_valid, cfg_valid, cfg_done, joy_update}, 64'h0);
    chk("rst_values", {core_id, cfg_byte, joy1, joy2}, 64'h0);
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    chk("rdy_before_edge", {63'b0, cmd_ready}, 64'd0);
    @(negedge clk);
    chk("rdy_after_edge", {63'b0, cmd_ready}, 64'd1);

    // 0x03: four argument bytes; pl_valid held high must never be accepted.
    pl_valid = 1'b1; pl_data = 8'h77;
    send_cmd(8'h03, 32'hDEADBEEF);
    wait_idle();
    chk("op03_bytes_at_ready", tx_q.size(), 5);
    chk("op03_data", qcat(), 64'h03DEADBEEF);
    chk("op03_no_pl", n_pl, 0);
    pl_valid = 1'b0; tx_q.delete();

    // 0x07 length 3, then a 4th payload offer.
    send_cmd(8'h07, 32'h0000_0003);
    send_pl(8'hAA); send_pl(8'hBB); send_pl(8'hCC);
    @(posedge clk); #1; pl_valid = 1'b1; pl_data = 8'hDD;
    wait_idle(); settle(100);
    pl_valid = 1'b0;
    chk("op07_pl_count", n_pl, 3);
    chk("op07_data", qcat(), 64'h07000003AABBCC);
    tx_q.delete();

    // 0x07 length 0: no payload phase.
    pl_valid = 1'b1; pl_data = 8'hEE;
    send_cmd(8'h07, 32'hFF00_0000);
    wait_idle(); settle(100);
    pl_valid = 1'b0;
    chk("op07_len0_pl", n_pl, 3);
    chk("op07_len0_data", qcat(), 64'h07000000);
    tx_q.delete();

    // 0x05: string up to and including NUL.
    send_cmd(8'h05, 32'h0);
    send_pl(8'h41); send_pl(8'h00);
    @(posedge clk); #1; pl_valid = 1'b1; pl_data = 8'h42;
    wait_idle(); settle(100);
    pl_valid = 1'b0;
    chk("op05_pl_count", n_pl, 5);
    chk("op05_data", qcat(), 64'h054100);
    tx_q.delete();

    // 0x04 x/y then 0x06 low byte only.
    send_cmd(8'h04, 32'hFFFF_1234); wait_idle();
    send_cmd(8'h06, 32'h1234_56AB); wait_idle();
    chk("op04_06_data", qcat(), 64'h04123406AB);
    tx_q.delete();

    // 0x01 and core ID response.
    send_cmd(8'h01, 32'h0);
    wait_txn(1);
    chk("op01_data", qcat(), 64'h01);
    chk("op01_busy_wait", {63'b0, busy}, 64'd1);
    fork
      begin rx_byte(8'h11); rx_byte(8'h01); end
      begin
        @(negedge clk);
        for (int t = 0; t < 1500 && !core_id_valid; t++) @(negedge clk);
        chk("cid_strobe", {63'b0, core_id_valid}, 64'd1);
        chk("cid_value", core_id, 64'h01);
        chk("busy_at_cid", {63'b0, busy}, 64'd1);
        @(negedge clk);
        chk("busy_after_cid", {63'b0, busy}, 64'd0);
      end
    join
    settle(5);
    chk("cid_count", n_cid, 1);
    tx_q.delete();

    // 0x02 with a joypad frame injected while waiting, then the string.
    send_cmd(8'h02, 32'h0);
    wait_txn(1);
    chk("op02_data", qcat(), 64'h02);
    rx_byte(8'h01); rx_byte(8'h34); rx_byte(8'h12); rx_byte(8'h78); rx_byte(8'h56);
    settle(20);
    chk("joy_values", {joy1, joy2}, 64'h12345678);
    chk("joy_count", n_joy, 1);
    chk("busy_during_joy", {63'b0, busy}, 64'd1);
    rx_byte(8'h22); rx_byte(8'h54); rx_byte(8'h61); rx_byte(8'h00);
    settle(20);
    chk("cfg_count", cfg_q.size(), 2);
    chk("cfg_bytes", {cfg_q[0], cfg_q[1]}, 64'h5461);
    chk("cfg_done_count", n_cfgd, 1);
    chk("busy_after_cfg", {63'b0, busy}, 64'd0);
    tx_q.delete();

    // String forced to end at STR_MAX bytes; next byte is a header again.
    rx_byte(8'h22); rx_byte(8'h41); rx_byte(8'h42); rx_byte(8'h43); rx_byte(8'h44);
    rx_byte(8'h11); rx_byte(8'h07);
    settle(20);
    chk("cfgmax_valid", n_cfgv, 6);
    chk("cfgmax_done", n_cfgd, 2);
    chk("cfgmax_cid", core_id, 64'h07);

    // Illegal opcodes and an illegal header.
    send_cmd(8'h09, 32'h0);
    settle(300);
    chk("op09_err", n_err, 1);
    chk("op09_no_tx", tx_q.size(), 0);
    chk("op09_ready", {63'b0, cmd_ready}, 64'd1);
    send_cmd(8'h00, 32'h0);
    settle(50);
    chk("op00_err", n_err, 2);
    rx_byte(8'h55);
    settle(20);
    chk("hdr55_err", n_err, 3);
    rx_byte(8'h11); rx_byte(8'h33);
    settle(20);
    chk("hdr55_recover", core_id, 64'h33);

    // Reset during a 0x07 payload byte.
    send_cmd(8'h07, 32'h0000_0003);
    send_pl(8'hAA);
    wait_txn(4);
    settle(30);
    @(posedge clk); #1 resetn = 1'b0;
    @(negedge clk);
    chk("midrst_uart_tx", {63'b0, uart_tx}, 64'd1);
    chk("midrst_status", {cmd_ready, pl_ready, busy}, 64'h0);
    chk("midrst_core_id", core_id, 64'h00);
    settle(5);
    @(posedge clk); #1 resetn = 1'b1;
    settle(150);
    tx_q.delete();
    send_cmd(8'h01, 32'h0);
    wait_txn(1);
    settle(100);
    chk("postrst_data", qcat(), 64'h01);
    rx_byte(8'h11); rx_byte(8'h22);
    settle(20);
    chk("postrst_cid", core_id, 64'h22);
    chk("postrst_idle", {63'b0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900_000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
